strength_bus_sampler: RTL and testbench
=======================================

// Module: strength_bus_sampler
// PURPOSE
//  Receive-side end of a strength-resolved shared bus: a W-bit net held at a weak
//  default value and conditionally overdriven by a strong driver. Samples the
//  resolved bus, qualifies each strongly driven word by requiring it stable for
//  STABLE cycles, and queues it in a DEPTH-entry FIFO with a valid/ready output.
//  Also counts X/Z samples and exports a registered single-bit tap of the bus.
// PARAMETERS
//  W       15      bus width, >= 1
//  DEFAULT '0      weak default value of the bus (W bits); this value never captures
//  STABLE  3       consecutive identical samples needed to capture, >= 1
//  DEPTH   4       output FIFO entries, power of 2, >= 2
//  TAP     W-5     bus bit index driven onto tap_o, 0 <= TAP < W
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      reset: synchronous, active-high
//  bus        in   W      resolved shared net (weak default + strong conditional driver)
//  out_valid  out  1      FIFO not empty
//  out_data   out  W      FIFO head word
//  out_ready  in   1      consumer accepts head when out_valid & out_ready
//  tap_o      out  1      bus[TAP], registered
//  overflow   out  1      sticky: a capture was dropped because the FIFO was full
//  xz_cnt     out  8      saturating count of sampled cycles with any X/Z bit
// BEHAVIOUR
//  Reset (rst=1 at an edge): s_q<=DEFAULT, state IDLE, cnt 0, FIFO empty,
//   out_valid 0, out_data 0, tap_o 0, overflow 0, xz_cnt 0. Reset wins over all events.
//  Sample stage: every edge s_q<=bus and tap_o<=bus[TAP]. The FSM reads s_q only.
//   Capture latency: bus first holds V before edge 1 -> out_valid high after edge
//   STABLE+1 if the FIFO was empty.
//  unknown = (^s_q === 1'bx); "known" means no X/Z bit. Compares use ===.
//  FSM states:
//   IDLE:     unknown -> stay. known & s_q!==DEFAULT -> SETTLE, cand<=s_q, cnt<=1.
//             If STABLE==1, push immediately and go to CAPTURED.
//   SETTLE:   unknown -> IDLE, cnt<=0. s_q===DEFAULT -> IDLE.
//             s_q===cand -> cnt+1; on reaching STABLE, push cand and go to CAPTURED.
//             Any other known value -> cand<=s_q, cnt<=1 (restart, stay SETTLE).
//   CAPTURED: stay until s_q===DEFAULT, then go to IDLE. Unknown or new values are
//             ignored, except for counting. One capture per drive episode.
//  xz_cnt: +1 on every edge where unknown, in any state; saturates at 255.
//  FIFO: push at capture. Pop when out_valid & out_ready.
//   Push while full with no pop -> word dropped and overflow<=1 (sticky until rst).
//   Push and pop on the same edge while full -> both take effect; no overflow.
//   Push into an empty FIFO -> word is visible the next cycle. No bypass path.
//   out_data is stable while out_valid & !out_ready.
//   Pointers wrap modulo DEPTH, with an extra bit for full/empty.
//  cnt width is $clog2(STABLE+1). cnt never exceeds STABLE.
// TESTING
//  1 bus=DEFAULT, then 15'h7FFF for 6 cycles, ready=1 -> out_valid pulses once
//    after edge 4 with out_data=7FFF. tap_o=1 from edge 1.
//  2 bus 0 -> 15'h0123 for 2 cycles -> 15'h0456 for 3 cycles -> 0 -> single
//    capture of 0456, none of 0123.
//  3 ready=0; six episodes A..F, each 4 cycles driven + 1 cycle DEFAULT -> A..D
//    held, overflow=1. Raise ready -> pops A,B,C,D in order.
//  4 bus has bit 3 = z for 5 cycles mid-SETTLE -> xz_cnt=5, no capture. Then a
//    clean value for 3 cycles -> captured.
//  5 Full FIFO with ready=1 on the edge a new word is captured -> head pops,
//    new word enters, overflow stays 0.
//  6 rst=1 for one edge during SETTLE with 2 words queued -> next cycle
//    out_valid=0, xz_cnt=0, overflow=0. A captured word appears only after a
//    fresh STABLE window.

Source files
------------

// File: rtl/strength_bus_sampler.sv
// Receive end of a strength-resolved bus: samples it, captures each strongly driven word once
// it has been stable for STABLE cycles, and queues captured words in a DEPTH-entry FIFO.
module strength_bus_sampler #(
    parameter int unsigned  W       = 15,
    parameter logic [W-1:0] DEFAULT = '0,
    parameter int unsigned  STABLE  = 3,
    parameter int unsigned  DEPTH   = 4,
    parameter int unsigned  TAP     = W - 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] bus,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         tap_o,
    output logic         overflow,
    output logic [7:0]   xz_cnt
);
    localparam int unsigned CW = $clog2(STABLE + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW:0] StableW = (CW + 1)'(STABLE);

    typedef enum logic [1:0] {StIdle, StSettle, StCaptured} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    s_q;
    logic            tap_q;
    logic [W-1:0]    cand_q, cand_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW:0]     cnt_inc;
    logic [W-1:0]    mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      xz_q, xz_d;
    logic            unknown;
    logic            push, pop, push_ok;
    logic            empty, full;

    assign unknown = (^s_q === 1'bx);
    assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

    // Sample stage, FSM state and FIFO storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q      <= DEFAULT;
            tap_q    <= 1'b0;
            state_q  <= StIdle;
            cand_q   <= DEFAULT;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            xz_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            s_q      <= bus;
            tap_q    <= bus[TAP];
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            xz_q     <= xz_d;
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= s_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (!unknown && (s_q !== DEFAULT)) begin
                    cand_d  = s_q;
                    cnt_d   = CW'(1);
                    state_d = (STABLE == 1) ? StCaptured : StSettle;
                end
            end
            StSettle: begin
                if (unknown || (s_q === DEFAULT)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (s_q === cand_q) begin
                    cnt_d = cnt_inc[CW-1:0];
                    if (cnt_inc == StableW) begin
                        state_d = StCaptured;
                    end
                end else begin
                    cand_d = s_q;
                    cnt_d  = CW'(1);
                end
            end
            StCaptured: begin
                // One capture per drive episode; only a return to the weak default re-arms.
                if (s_q === DEFAULT) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        push = 1'b0;
        unique case (state_q)
            StIdle:   push = (STABLE == 1) && !unknown && (s_q !== DEFAULT);
            StSettle: push = !unknown && (s_q !== DEFAULT) && (s_q === cand_q) &&
                             (cnt_inc == StableW);
            default:  push = 1'b0;
        endcase
    end

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = !empty && out_ready;
        push_ok  = push && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
        ovf_d    = ovf_q | (push && full && !pop);
        xz_d     = (unknown && (xz_q != 8'hFF)) ? xz_q + 8'd1 : xz_q;
    end

    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign tap_o     = tap_q;
    assign overflow  = ovf_q;
    assign xz_cnt    = xz_q;

endmodule

// File: tb/tb_strength_bus_sampler.sv
// Randomised and directed bench for strength_bus_sampler against a run-length reference model.
module tb_strength_bus_sampler;
    localparam int unsigned  W       = 15;
    localparam logic [W-1:0] DEFAULT = '0;
    localparam int unsigned  STABLE  = 3;
    localparam int unsigned  DEPTH   = 4;
    localparam int unsigned  TAP     = W - 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] bus = DEFAULT;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         tap_o;
    logic         overflow;
    logic [7:0]   xz_cnt;

    strength_bus_sampler #(
        .W       (W),
        .DEFAULT (DEFAULT),
        .STABLE  (STABLE),
        .DEPTH   (DEPTH),
        .TAP     (TAP)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .tap_o     (tap_o),
        .overflow  (overflow),
        .xz_cnt    (xz_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: a word is captured when it has been the sampled value for STABLE
    // consecutive edges, at most once between two samples of the default value.
    logic [W-1:0] m_s;
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_last;
    logic         m_ovf;
    logic         m_tap;
    logic         m_done;
    int unsigned  m_xz;
    int unsigned  m_run;

    task automatic check_val(input string tag, input logic [W-1:0] obs,
                             input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [W-1:0] b, input logic rdy);
        logic unk;
        logic cap;
        logic do_pop;
        if (r) begin
            m_s    = DEFAULT;
            m_q.delete();
            m_last = DEFAULT;
            m_ovf  = 1'b0;
            m_tap  = 1'b0;
            m_done = 1'b0;
            m_xz   = 0;
            m_run  = 0;
            return;
        end
        unk = $isunknown(m_s);
        cap = 1'b0;
        if (unk && m_xz < 255) m_xz++;
        if (unk) begin
            m_run = 0;
        end else if (m_s === DEFAULT) begin
            m_run  = 0;
            m_done = 1'b0;
        end else begin
            if (m_run > 0 && m_s === m_last) m_run++;
            else begin
                m_run  = 1;
                m_last = m_s;
            end
            if (!m_done && m_run == STABLE) begin
                cap    = 1'b1;
                m_done = 1'b1;
            end
        end
        do_pop = (m_q.size() > 0) && rdy;
        if (do_pop) void'(m_q.pop_front());
        if (cap) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_s);
            else m_ovf = 1'b1;
        end
        m_s   = b;
        m_tap = b[TAP];
    endtask

    task automatic step(input logic r, input logic [W-1:0] b, input logic rdy);
        rst       = r;
        bus       = b;
        out_ready = rdy;
        @(posedge clk);
        model_edge(r, b, rdy);
        #1;
        check_val("out_valid", out_valid, (m_q.size() > 0));
        if (m_q.size() > 0) check_val("out_data", out_data, m_q[0]);
        else if (r) check_val("out_data_rst", out_data, '0);
        check_val("overflow", overflow, m_ovf);
        check_val("xz_cnt", xz_cnt, W'(m_xz));
        check_val("tap_o", tap_o, m_tap);
    endtask

    task automatic drive(input logic [W-1:0] v, input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, v, rdy);
    endtask

    logic [W-1:0] vals[4] = '{15'h1234, 15'h7FFF, 15'h0400, 15'h2AAA};

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] xv;

        step(1'b1, DEFAULT, 1'b0);
        step(1'b1, DEFAULT, 1'b0);

        // Single clean episode with the consumer always ready.
        drive(DEFAULT, 2, 1'b1);
        drive(15'h7FFF, 6, 1'b1);
        drive(DEFAULT, 2, 1'b1);

        // Short value then a longer one: only the second is captured.
        drive(15'h0123, 2, 1'b1);
        drive(15'h0456, 3, 1'b1);
        drive(DEFAULT, 3, 1'b1);

        // Six episodes into a stalled FIFO, then drain.
        drive(DEFAULT, 1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(15'h0A00 + W'(i), 4, 1'b0);
            drive(DEFAULT, 1, 1'b0);
        end
        drive(DEFAULT, 6, 1'b1);

        // Z bit mid-settle, then a clean value.
        step(1'b1, DEFAULT, 1'b0);
        drive(15'h0222, 2, 1'b1);
        v    = 15'h0222;
        v[3] = 1'bz;
        drive(v, 5, 1'b1);
        drive(15'h0333, 4, 1'b1);
        drive(DEFAULT, 2, 1'b1);

        // Full FIFO with a pop on the same edge as a new capture.
        step(1'b1, DEFAULT, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(15'h0B00 + W'(i), 4, 1'b0);
            drive(DEFAULT, 1, 1'b0);
        end
        drive(15'h5555, 3, 1'b0);
        step(1'b0, 15'h5555, 1'b1);
        drive(15'h5555, 1, 1'b0);
        drive(DEFAULT, 1, 1'b0);
        drive(DEFAULT, 6, 1'b1);

        // Reset mid-settle with two words queued.
        for (int i = 0; i < 2; i++) begin
            drive(15'h0C00 + W'(i), 4, 1'b0);
            drive(DEFAULT, 1, 1'b0);
        end
        drive(15'h6666, 2, 1'b0);
        step(1'b1, 15'h6666, 1'b0);
        drive(15'h6666, 5, 1'b1);
        drive(DEFAULT, 2, 1'b1);

        // Long unknown stretch exercises xz_cnt saturation.
        xv = 'x;
        drive(xv, 260, 1'b1);
        drive(DEFAULT, 2, 1'b1);
        step(1'b1, DEFAULT, 1'b0);

        // Random episodes.
        for (int e = 0; e < 150; e++) begin
            int unsigned sel;
            int unsigned len;
            sel = $urandom_range(0, 9);
            len = $urandom_range(1, 5);
            if (sel <= 2) v = DEFAULT;
            else if (sel == 3) v = 'x;
            else if (sel <= 7) v = vals[$urandom_range(0, 3)];
            else v = W'($urandom);
            for (int c = 0; c < int'(len); c++) begin
                step(($urandom_range(0, 199) == 0), v, ($urandom_range(0, 3) != 0));
            end
        end
        drive(DEFAULT, 8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
